token_encoder: RTL and testbench

//  Parametrised greedy longest-match tokenizer; successor to the fixed-size encoder datapath.

---
 rtl/token_encoder_pkg.sv | 28 ++
 rtl/token_encoder_if.sv | 45 ++++
 rtl/token_encoder_slot_cmp.sv | 36 +++
 rtl/token_encoder.sv | 238 +++++++++++++++++++++++
 tb/tb_token_encoder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/token_encoder_pkg.sv
// -----------------------------------------------------------------------------
// token_encoder_pkg
// Shared types and constants for the greedy longest-match token encoder.
//   tok_enc_state_t : encoder FSM state encoding
//   SYM_NUL         : terminator / padding symbol value for text and vocab
//   idx_w()         : index width helper that never returns zero
// -----------------------------------------------------------------------------
package token_encoder_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK  = 3'd1,
        CHKW = 3'd2,
        RD   = 3'd3,
        CMP  = 3'd4,
        EMIT = 3'd5,
        DONE = 3'd6
    } tok_enc_state_t;

    localparam int SYM_NUL = 0;

    // Width of an index into n items; a single item still gets one bit so
    // no zero-width vectors are ever declared.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/token_encoder_if.sv
// -----------------------------------------------------------------------------
// token_encoder_if
// Bundles the encoder's memory read ports and its output code stream.
//   text_addr / text_dout   : text SRAM read port (data one cycle after addr)
//   vocab_addr / vocab_dout : vocab SRAM read port (data one cycle after addr)
//   code_valid / code / code_ready : valid/ready output code stream
// Modports:
//   master : the encoder side (drives addresses and codes)
//   slave  : memories plus downstream consumer
// -----------------------------------------------------------------------------
interface token_encoder_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int TEXT_ADDR_W = 4,
    parameter int VA_W        = 6,
    parameter int CODE_W      = 8
);
    logic [TEXT_ADDR_W-1:0] text_addr;
    logic [DATA_WIDTH-1:0]  text_dout;
    logic [VA_W-1:0]        vocab_addr;
    logic [DATA_WIDTH-1:0]  vocab_dout;
    logic                   code_valid;
    logic [CODE_W-1:0]      code;
    logic                   code_ready;

    modport master (
        output text_addr,
        input  text_dout,
        output vocab_addr,
        input  vocab_dout,
        output code_valid,
        output code,
        input  code_ready
    );

    modport slave (
        input  text_addr,
        output text_dout,
        input  vocab_addr,
        output vocab_dout,
        input  code_valid,
        input  code,
        output code_ready
    );

endinterface

// File: rtl/token_encoder_slot_cmp.sv
// -----------------------------------------------------------------------------
// token_slot_cmp
// Combinational resolution of byte j of the vocab slot under comparison.
//   vocab_dout : slot byte j
//   text_dout  : text byte at pos+j
//   j          : byte index within the slot
//   text_oob   : pos+j ran past the text memory (treated as a terminator)
//   slot_end   : slot is exhausted at j (its length is j)
//   mismatch   : slot rejected at this position
//   full       : last slot byte matched, slot length is MAX_TOK_LEN
// -----------------------------------------------------------------------------
module token_slot_cmp
    import token_encoder_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_TOK_LEN = 4,
    parameter int JW          = 2
) (
    input  logic [DATA_WIDTH-1:0] vocab_dout,
    input  logic [DATA_WIDTH-1:0] text_dout,
    input  logic [JW-1:0]         j,
    input  logic                  text_oob,
    output logic                  slot_end,
    output logic                  mismatch,
    output logic                  full
);

    // A slot ending here wins over anything the text says at this byte, so a
    // text terminator (or out-of-range position) only rejects slots that
    // still expect more bytes. A text NUL against a non-NUL vocab byte falls
    // out of the plain inequality.
    assign slot_end = (vocab_dout == DATA_WIDTH'(SYM_NUL));
    assign mismatch = !slot_end && (text_oob || (vocab_dout != text_dout));
    assign full     = !slot_end && !mismatch && (j == JW'(MAX_TOK_LEN - 1));

endmodule

// File: rtl/token_encoder.sv
// -----------------------------------------------------------------------------
// token_encoder
// Greedy longest-match tokenizer. Reads a NUL-terminated string from a text
// SRAM, compares every vocab slot at the current position, and emits the
// index of the longest matching slot (lowest index on ties) or UNK_CODE.
//
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : begin encoding at text address 0 (honoured in IDLE/DONE only)
//   bus      : token_encoder_if.master (text/vocab read ports, code stream)
//   busy     : run in progress
//   done     : run finished, held until the next start
//   n_codes  : codes accepted by the consumer this run
//   unk_cnt  : accepted UNK codes this run, saturating
//              (present only when TOKEN_ENCODER_UNK_CNT_EN is defined)
// -----------------------------------------------------------------------------
module token_encoder
    import token_encoder_pkg::*;
#(
    parameter int                DATA_WIDTH  = 8,
    parameter int                TEXT_ADDR_W = 4,
    parameter int                N_TOKENS    = 16,
    parameter int                MAX_TOK_LEN = 4,
    parameter int                CODE_W      = 8,
    parameter logic [CODE_W-1:0] UNK_CODE    = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    token_encoder_if.master        bus,
    output logic                   busy,
    output logic                   done,
`ifdef TOKEN_ENCODER_UNK_CNT_EN
    output logic [TEXT_ADDR_W:0]   unk_cnt,
`endif
    output logic [TEXT_ADDR_W:0]   n_codes
);

    localparam int VA_W = $clog2(N_TOKENS * MAX_TOK_LEN);
    localparam int JW   = idx_w(MAX_TOK_LEN);
    localparam int KW   = idx_w(N_TOKENS);
    localparam int LW   = $clog2(MAX_TOK_LEN) + 1;
    localparam int PW   = TEXT_ADDR_W + 1;   // one spare bit flags running off the text

    tok_enc_state_t          state_reg;
    logic [PW-1:0]           pos_reg;
    logic [JW-1:0]           j_reg;
    logic [KW-1:0]           k_reg;
    logic [LW-1:0]           best_len_reg;
    logic [KW-1:0]           best_code_reg;
    logic [TEXT_ADDR_W-1:0]  text_addr_reg;
    logic                    text_oob_reg;
    logic [VA_W-1:0]         vocab_addr_reg;
    logic                    code_valid_reg;
    logic [CODE_W-1:0]       code_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [PW-1:0]           n_codes_reg;
`ifdef TOKEN_ENCODER_UNK_CNT_EN
    logic [PW-1:0]           unk_cnt_reg;
`endif

    // Slot comparison results for the byte currently on the SRAM outputs.
    logic                    slot_end;
    logic                    slot_mismatch;
    logic                    slot_full;

    token_slot_cmp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_TOK_LEN (MAX_TOK_LEN),
        .JW          (JW)
    ) u_slot_cmp (
        .vocab_dout (bus.vocab_dout),
        .text_dout  (bus.text_dout),
        .j          (j_reg),
        .text_oob   (text_oob_reg),
        .slot_end   (slot_end),
        .mismatch   (slot_mismatch),
        .full       (slot_full)
    );

    function automatic logic [VA_W-1:0] slot_addr(input logic [KW-1:0] k,
                                                  input logic [JW-1:0] j);
        return VA_W'(int'(k) * MAX_TOK_LEN + int'(j));
    endfunction

    logic                    slot_done;
    logic                    last_slot;
    logic [LW-1:0]           slot_len;
    logic                    slot_take;
    logic [LW-1:0]           best_len_next;
    logic [KW-1:0]           best_code_next;
    logic [CODE_W-1:0]       emit_code_next;
    logic [KW-1:0]           rd_k_next;
    logic [JW-1:0]           rd_j_next;
    logic [PW-1:0]           rd_text_next;
    logic [PW-1:0]           adv_next;
    logic [PW-1:0]           pos_next;

    assign slot_done = slot_end | slot_mismatch | slot_full;
    assign last_slot = (k_reg == KW'(N_TOKENS - 1));
    assign slot_len  = slot_full ? LW'(MAX_TOK_LEN) : LW'(j_reg);

    // Strict comparison keeps the earliest slot on equal lengths, and an
    // empty slot (length 0) can never beat the initial best_len of 0.
    assign slot_take      = (slot_end | slot_full) && (slot_len > best_len_reg);
    assign best_len_next  = slot_take ? slot_len : best_len_reg;
    assign best_code_next = slot_take ? k_reg    : best_code_reg;
    assign emit_code_next = (best_len_next != '0) ? CODE_W'(best_code_next) : UNK_CODE;

    // Next byte to fetch: either the following byte of this slot or byte 0
    // of the next slot.
    assign rd_k_next    = slot_done ? (k_reg + KW'(1)) : k_reg;
    assign rd_j_next    = slot_done ? '0 : (j_reg + JW'(1));
    assign rd_text_next = pos_reg + PW'(rd_j_next);

    // An unknown byte still consumes one position so the scan always advances.
    assign adv_next = (best_len_reg == '0) ? PW'(1) : PW'(best_len_reg);
    assign pos_next = pos_reg + adv_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pos_reg        <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            best_len_reg   <= '0;
            best_code_reg  <= '0;
            text_addr_reg  <= '0;
            text_oob_reg   <= 1'b0;
            vocab_addr_reg <= '0;
            code_valid_reg <= 1'b0;
            code_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            n_codes_reg    <= '0;
`ifdef TOKEN_ENCODER_UNK_CNT_EN
            unk_cnt_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg     <= CHK;
                        pos_reg       <= '0;
                        n_codes_reg   <= '0;
                        text_addr_reg <= '0;
                        text_oob_reg  <= 1'b0;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
`ifdef TOKEN_ENCODER_UNK_CNT_EN
                        unk_cnt_reg   <= '0;
`endif
                    end
                end

                // text_addr already holds pos; wait for the read data.
                CHK: begin
                    state_reg <= CHKW;
                end

                CHKW: begin
                    if (text_oob_reg || (bus.text_dout == DATA_WIDTH'(SYM_NUL))) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        // text_addr still equals pos+0, so only the vocab
                        // address needs loading for slot 0 byte 0.
                        k_reg          <= '0;
                        j_reg          <= '0;
                        best_len_reg   <= '0;
                        best_code_reg  <= '0;
                        vocab_addr_reg <= '0;
                        state_reg      <= RD;
                    end
                end

                RD: begin
                    state_reg <= CMP;
                end

                CMP: begin
                    best_len_reg  <= best_len_next;
                    best_code_reg <= best_code_next;
                    if (slot_done && last_slot) begin
                        code_reg       <= emit_code_next;
                        code_valid_reg <= 1'b1;
                        state_reg      <= EMIT;
                    end else begin
                        k_reg          <= rd_k_next;
                        j_reg          <= rd_j_next;
                        text_addr_reg  <= rd_text_next[TEXT_ADDR_W-1:0];
                        text_oob_reg   <= rd_text_next[TEXT_ADDR_W];
                        vocab_addr_reg <= slot_addr(rd_k_next, rd_j_next);
                        state_reg      <= RD;
                    end
                end

                // Code and both addresses hold until the consumer takes it.
                EMIT: begin
                    if (bus.code_ready) begin
                        code_valid_reg <= 1'b0;
                        pos_reg        <= pos_next;
                        n_codes_reg    <= n_codes_reg + PW'(1);
                        text_addr_reg  <= pos_next[TEXT_ADDR_W-1:0];
                        text_oob_reg   <= pos_next[TEXT_ADDR_W];
`ifdef TOKEN_ENCODER_UNK_CNT_EN
                        // best_len==0 identifies UNK even if UNK_CODE could
                        // alias a real slot index.
                        if ((best_len_reg == '0) && (unk_cnt_reg != '1)) begin
                            unk_cnt_reg <= unk_cnt_reg + PW'(1);
                        end
`endif
                        state_reg      <= CHK;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.text_addr  = text_addr_reg;
    assign bus.vocab_addr = vocab_addr_reg;
    assign bus.code_valid = code_valid_reg;
    assign bus.code       = code_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign n_codes        = n_codes_reg;
`ifdef TOKEN_ENCODER_UNK_CNT_EN
    assign unk_cnt        = unk_cnt_reg;
`endif

endmodule

// File: tb/tb_token_encoder.sv
// -----------------------------------------------------------------------------
// tb_token_encoder
// Directed bench for token_encoder with behavioural text/vocab SRAMs and a
// queue of expected codes per run.
// -----------------------------------------------------------------------------
module tb_token_encoder;
    import token_encoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] n_codes;
`ifdef TOKEN_ENCODER_UNK_CNT_EN
    logic [4:0] unk_cnt;
`endif

    token_encoder_if #(
        .DATA_WIDTH  (8),
        .TEXT_ADDR_W (4),
        .VA_W        (6),
        .CODE_W      (8)
    ) bus ();

    token_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
`ifdef TOKEN_ENCODER_UNK_CNT_EN
        .unk_cnt (unk_cnt),
`endif
        .n_codes (n_codes)
    );

    always #5 clk = ~clk;

    logic [7:0] text_mem  [16];
    logic [7:0] vocab_mem [64];

    always @(posedge clk) begin
        bus.text_dout  <= text_mem[bus.text_addr];
        bus.vocab_dout <= vocab_mem[bus.vocab_addr];
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) text_mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) vocab_mem[i] = 8'h00;
    endtask

    task automatic set_slot(input int k, input string s);
        for (int i = 0; i < s.len(); i++) vocab_mem[k*4+i] = s[i];
    endtask

    task automatic set_text(input string s);
        for (int i = 0; i < 16; i++) text_mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) text_mem[i] = s[i];
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Start a run with code_ready high, compare every accepted code against
    // the queue, and check the end-of-run counters.
    task automatic run_enc(input string tag, input int exp_n);
        int         xfers;
        logic [7:0] e;
        xfers = 0;
        bus.code_ready = 1'b1;
        pulse_start();
        for (int g = 0; g < 3000; g++) begin
            if (done) break;
            if (bus.code_valid && bus.code_ready) begin
                xfers++;
                $display("%s: transfer %0d code=%02h", tag, xfers, bus.code);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_code"}, 32'(bus.code), 32'(e));
                end
            end
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_xfers"}, 32'(xfers), 32'(exp_n));
        check({tag, "_n_codes"}, 32'(n_codes), 32'(exp_n));
        exp_q.delete();
    endtask

    task automatic setup_t1();
        clear_mem();
        set_slot(0, "ab");
        set_slot(1, "abc");
        set_slot(2, "c");
        set_text("abcc");
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.code_ready = 1'b1;
        clear_mem();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_done",       32'(done),           32'd0);
        check("rst_valid",      32'(bus.code_valid), 32'd0);
        check("rst_code",       32'(bus.code),       32'd0);
        check("rst_n_codes",    32'(n_codes),        32'd0);
        check("rst_text_addr",  32'(bus.text_addr),  32'd0);
        check("rst_vocab_addr", 32'(bus.vocab_addr), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: longest match wins, then a single-byte slot
        setup_t1();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        run_enc("t1", 2);

        // 2: equal-length tie goes to the lower slot
        clear_mem();
        set_slot(3, "a");
        set_slot(5, "a");
        set_text("a");
        exp_q.push_back(8'h03);
        run_enc("t2", 1);

        // 3: nothing matches
        setup_t1();
        set_text("zq");
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        run_enc("t3", 2);
`ifdef TOKEN_ENCODER_UNK_CNT_EN
        check("t3_unk_cnt", 32'(unk_cnt), 32'd2);
`endif

        // 4: empty text, done three cycles after start
        set_text("");
        pulse_start();
        check("t4_busy_c1", 32'(busy), 32'd1);
        check("t4_done_c1", 32'(done), 32'd0);
        @(negedge clk);
        check("t4_done_c2", 32'(done), 32'd0);
        @(negedge clk);
        check("t4_done_c3", 32'(done), 32'd1);
        check("t4_busy_c3", 32'(busy), 32'd0);
        check("t4_n_codes", 32'(n_codes), 32'd0);
        check("t4_valid",   32'(bus.code_valid), 32'd0);

        // 5: backpressure during EMIT
        setup_t1();
        bus.code_ready = 1'b0;
        pulse_start();
        for (int g = 0; g < 3000 && !bus.code_valid; g++) @(negedge clk);
        check("t5_valid", 32'(bus.code_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            check("t5_hold_code",  32'(bus.code),       32'h01);
            check("t5_hold_valid", 32'(bus.code_valid), 32'd1);
            check("t5_hold_taddr", 32'(bus.text_addr),  32'd0);
            check("t5_hold_vaddr", 32'(bus.vocab_addr), 32'd60);
            @(negedge clk);
        end
        bus.code_ready = 1'b1;
        @(posedge clk);
        #1 bus.code_ready = 1'b0;
        @(negedge clk);
        $display("t5: transfer 1 accepted after stall");
        check("t5_one_xfer",   32'(n_codes),        32'd1);
        check("t5_valid_drop", 32'(bus.code_valid), 32'd0);
        for (int g = 0; g < 3000 && !bus.code_valid; g++) @(negedge clk);
        check("t5_code2",  32'(bus.code),      32'h02);
        check("t5_taddr2", 32'(bus.text_addr), 32'd3);
        exp_q.delete();
        bus.code_ready = 1'b1;
        for (int g = 0; g < 3000 && !done; g++) @(negedge clk);
        $display("t5: transfer 2 code=02");
        check("t5_done",    32'(done),    32'd1);
        check("t5_n_codes", 32'(n_codes), 32'd2);

        // 6: reset mid-CMP, then identical re-run
        setup_t1();
        bus.code_ready = 1'b1;
        pulse_start();
        for (int g = 0; g < 200 && dut.state_reg != CMP; g++) @(negedge clk);
        check("t6_in_cmp", 32'(dut.state_reg), 32'(CMP));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_state",   32'(dut.state_reg),  32'(IDLE));
        check("t6_busy",    32'(busy),           32'd0);
        check("t6_done",    32'(done),           32'd0);
        check("t6_valid",   32'(bus.code_valid), 32'd0);
        check("t6_n_codes", 32'(n_codes),        32'd0);
        check("t6_taddr",   32'(bus.text_addr),  32'd0);
        check("t6_vaddr",   32'(bus.vocab_addr), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        run_enc("t6", 2);

        // 7: full-length slot and running off the end of text memory
        clear_mem();
        set_slot(4, "xxxx");
        set_slot(6, "x");
        set_text("qqxxxxxxxxxxxxxx");
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h06);
        run_enc("t7", 7);
`ifdef TOKEN_ENCODER_UNK_CNT_EN
        check("t7_unk_cnt", 32'(unk_cnt), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
